// File: rtl/hps_io_sequencer_if.sv
// Client-side command/payload/response port of the HPS word sequencer.
// master = sequencer, slave = downstream client.
interface hps_io_sequencer_if #(
    parameter int IDX_W = 8
) ();
    logic             cmd_valid;
    logic [7:0]       cmd_code;
    logic             cmd_active;
    logic             cmd_end;
    logic             data_valid;
    logic [15:0]      data_out;
    logic [IDX_W-1:0] data_idx;
    logic             data_ready;
    logic [IDX_W-1:0] rsp_idx;
    logic [15:0]      rsp_data;

    modport master (
        output cmd_valid,
        output cmd_code,
        output cmd_active,
        output cmd_end,
        output data_valid,
        output data_out,
        output data_idx,
        input  data_ready,
        output rsp_idx,
        input  rsp_data
    );

    modport slave (
        input  cmd_valid,
        input  cmd_code,
        input  cmd_active,
        input  cmd_end,
        input  data_valid,
        input  data_out,
        input  data_idx,
        output data_ready,
        input  rsp_idx,
        output rsp_data
    );
endinterface

// File: rtl/hps_io_sequencer.sv
// HPS SPI command-frame sequencer: frames words by io_enable, answers
// version/status locally and forwards other commands to one client.
module hps_io_sequencer #(
    parameter int          IDX_W      = 8,
    parameter logic [15:0] VERSION    = 16'h0001,
    parameter logic [7:0]  OP_VERSION = 8'hFF,
    parameter logic [7:0]  OP_STATUS  = 8'hFE
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic        io_enable,
    input  logic        io_strobe,
    input  logic [15:0] io_din,
    output logic [15:0] io_dout,
    output logic        overrun,
    input  logic        ovr_clr,
    hps_io_sequencer_if.master cl
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FWD,
        S_LOCAL
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_en_d;
    logic             r_cmd_valid;
    logic [7:0]       r_cmd_code;
    logic             r_cmd_active;
    logic             r_cmd_end;
    logic             r_data_valid;
    logic [15:0]      r_data_out;
    logic [IDX_W-1:0] r_data_idx;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_cnt;
    logic             r_overrun;
    logic             r_rsp_pend;
    logic [15:0]      r_io_dout;

    logic             w_start;
    logic             w_end;
    logic             w_local_op;
    logic             w_cmd;
    logic             w_fwd_cmd;
    logic             w_fwd_wd;
    logic             w_loc_wd;
    logic             w_accept;
    logic             w_drop;
    logic             w_load;
    logic [15:0]      w_local_rsp;
    logic [15:0]      w_rsp;

    assign w_start = io_enable & ~r_en_d;
    assign w_end   = ~io_enable & r_en_d;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start) w_next = S_WAIT;
            S_WAIT: begin
                if (io_strobe) begin
                    w_next = w_local_op ? S_LOCAL : S_FWD;
                end
            end
            default: w_next = r_state;
        endcase
        // a closing frame wins over any transition taken above
        if (w_end) w_next = S_IDLE;
    end

    always_comb begin
        w_local_op = (io_din[7:0] == OP_VERSION) |
                     (io_din[7:0] == OP_STATUS);
        w_cmd      = io_strobe & (r_state == S_WAIT);
        w_fwd_cmd  = w_cmd & ~w_local_op;
        w_fwd_wd   = io_strobe & (r_state == S_FWD);
        w_loc_wd   = io_strobe & (r_state == S_LOCAL);
        w_accept   = r_data_valid & cl.data_ready;
        w_drop     = w_fwd_wd & r_data_valid & ~cl.data_ready;
        w_load     = w_fwd_wd & ~w_drop;
        if (r_cmd_code == OP_VERSION) begin
            w_local_rsp = VERSION;
        end else begin
            w_local_rsp = {r_overrun, 7'b0, r_cnt};
        end
        w_rsp = (r_state == S_LOCAL) ? w_local_rsp : cl.rsp_data;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en_d       <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_code   <= '0;
            r_cmd_active <= 1'b0;
            r_cmd_end    <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
            r_data_idx   <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_overrun    <= 1'b0;
            r_rsp_pend   <= 1'b0;
            r_io_dout    <= '0;
        end else begin
            r_en_d      <= io_enable;
            r_cmd_valid <= w_fwd_cmd;
            r_cmd_end   <= w_end & (r_state == S_FWD);

            if (w_cmd) r_cmd_code <= io_din[7:0];

            if (w_end) begin
                r_cmd_active <= 1'b0;
            end else if (w_fwd_cmd) begin
                r_cmd_active <= 1'b1;
            end

            if (w_cmd) begin
                r_idx <= '0;
            end else if (w_fwd_wd && r_idx != '1) begin
                r_idx <= r_idx + 1'b1;
            end

            if (w_cmd) begin
                r_cnt <= '0;
            end else if ((w_fwd_wd | w_loc_wd) && r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end

            // a pending word survives frame end until the client takes it
            if (w_load) begin
                r_data_valid <= 1'b1;
                r_data_out   <= io_din;
                r_data_idx   <= r_idx;
            end else if (w_accept) begin
                r_data_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end

            // one cycle for rsp_idx to settle, then sample the response
            r_rsp_pend <= (w_cmd | w_fwd_wd | w_loc_wd) & ~w_end;

            if (w_end) begin
                r_io_dout <= '0;
            end else if (r_rsp_pend) begin
                r_io_dout <= w_rsp;
            end
        end
    end

    assign io_dout       = r_io_dout;
    assign overrun       = r_overrun;
    assign cl.cmd_valid  = r_cmd_valid;
    assign cl.cmd_code   = r_cmd_code;
    assign cl.cmd_active = r_cmd_active;
    assign cl.cmd_end    = r_cmd_end;
    assign cl.data_valid = r_data_valid;
    assign cl.data_out   = r_data_out;
    assign cl.data_idx   = r_data_idx;
    assign cl.rsp_idx    = r_idx;

endmodule

// File: tb/tb_hps_io_sequencer.sv
// Directed bench for hps_io_sequencer: per-cycle vector table plus
// hand-written reset-in-frame sequence.
module tb_hps_io_sequencer;
    localparam int IDX_W = 2;

    logic        sys_clk   = 1'b0;
    logic        reset_n   = 1'b0;
    logic        io_enable = 1'b0;
    logic        io_strobe = 1'b0;
    logic [15:0] io_din    = '0;
    logic        ovr_clr   = 1'b0;
    logic [15:0] io_dout;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    hps_io_sequencer_if #(.IDX_W(IDX_W)) cl ();

    hps_io_sequencer #(.IDX_W(IDX_W)) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .io_enable (io_enable),
        .io_strobe (io_strobe),
        .io_din    (io_din),
        .io_dout   (io_dout),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr),
        .cl        (cl)
    );

    always #5 sys_clk = ~sys_clk;

    // client model: response word derived from requested index
    assign cl.rsp_data = 16'h1200 + 16'(cl.rsp_idx);

    typedef struct {
        logic        en;
        logic        st;
        logic [15:0] din;
        logic        rdy;
        logic        clr;
        logic        cv;
        logic [7:0]  code;
        logic        act;
        logic        ce;
        logic        dv;
        logic [15:0] dout;
        logic [1:0]  didx;
        logic        ov;
        logic [15:0] iod;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic en, input logic st, input logic [15:0] din,
        input logic rdy, input logic clr,
        input logic cv, input logic [7:0] code, input logic act,
        input logic ce, input logic dv, input logic [15:0] dout,
        input logic [1:0] didx, input logic ov, input logic [15:0] iod);
        vec_t v;
        v.en = en; v.st = st; v.din = din; v.rdy = rdy; v.clr = clr;
        v.cv = cv; v.code = code; v.act = act; v.ce = ce; v.dv = dv;
        v.dout = dout; v.didx = didx; v.ov = ov; v.iod = iod;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string t,
        input logic cv, input logic [7:0] code, input logic act,
        input logic ce, input logic dv, input logic [15:0] dout,
        input logic [1:0] didx, input logic ov, input logic [15:0] iod);
        chk({t, ".cmd_valid"},  16'(cl.cmd_valid),  16'(cv));
        chk({t, ".cmd_code"},   16'(cl.cmd_code),   16'(code));
        chk({t, ".cmd_active"}, 16'(cl.cmd_active), 16'(act));
        chk({t, ".cmd_end"},    16'(cl.cmd_end),    16'(ce));
        chk({t, ".data_valid"}, 16'(cl.data_valid), 16'(dv));
        chk({t, ".data_out"},   cl.data_out,        dout);
        chk({t, ".data_idx"},   16'(cl.data_idx),   16'(didx));
        chk({t, ".overrun"},    16'(overrun),       16'(ov));
        chk({t, ".io_dout"},    io_dout,            iod);
    endtask

    task automatic drive(input logic en, input logic st,
                         input logic [15:0] din, input logic rdy,
                         input logic clr);
        io_enable     = en;
        io_strobe     = st;
        io_din        = din;
        cl.data_ready = rdy;
        ovr_clr       = clr;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    initial begin
        cl.data_ready = 1'b0;
        #1;
        check_all("reset", 0, 8'h00, 0, 0, 0, 16'h0, 0, 0, 16'h0);
        chk("reset.rsp_idx", 16'(cl.rsp_idx), 16'h0);
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;

        // forwarded frame, client always ready
        vq.push_back(mk(1,0,16'h0000,1,0, 0,8'h00,0,0,0,16'h0000,0,0,16'h0000));
        vq.push_back(mk(1,1,16'h0010,1,0, 1,8'h10,1,0,0,16'h0000,0,0,16'h0000));
        vq.push_back(mk(1,0,16'h0000,1,0, 0,8'h10,1,0,0,16'h0000,0,0,16'h1200));
        vq.push_back(mk(1,1,16'hAAAA,1,0, 0,8'h10,1,0,1,16'hAAAA,0,0,16'h1200));
        vq.push_back(mk(1,0,16'h0000,1,0, 0,8'h10,1,0,0,16'hAAAA,0,0,16'h1201));
        vq.push_back(mk(1,1,16'hBBBB,1,0, 0,8'h10,1,0,1,16'hBBBB,1,0,16'h1201));
        vq.push_back(mk(1,0,16'h0000,1,0, 0,8'h10,1,0,0,16'hBBBB,1,0,16'h1202));
        vq.push_back(mk(0,0,16'h0000,1,0, 0,8'h10,0,1,0,16'hBBBB,1,0,16'h0000));
        vq.push_back(mk(0,0,16'h0000,1,0, 0,8'h10,0,0,0,16'hBBBB,1,0,16'h0000));
        // version readback
        vq.push_back(mk(1,0,16'h0000,1,0, 0,8'h10,0,0,0,16'hBBBB,1,0,16'h0000));
        vq.push_back(mk(1,1,16'h00FF,1,0, 0,8'hFF,0,0,0,16'hBBBB,1,0,16'h0000));
        vq.push_back(mk(1,0,16'h0000,1,0, 0,8'hFF,0,0,0,16'hBBBB,1,0,16'h0001));
        vq.push_back(mk(0,0,16'h0000,1,0, 0,8'hFF,0,0,0,16'hBBBB,1,0,16'h0000));
        // status readback with three payload words
        vq.push_back(mk(1,0,16'h0000,1,0, 0,8'hFF,0,0,0,16'hBBBB,1,0,16'h0000));
        vq.push_back(mk(1,1,16'h00FE,1,0, 0,8'hFE,0,0,0,16'hBBBB,1,0,16'h0000));
        vq.push_back(mk(1,0,16'h0000,1,0, 0,8'hFE,0,0,0,16'hBBBB,1,0,16'h0000));
        vq.push_back(mk(1,1,16'h1111,1,0, 0,8'hFE,0,0,0,16'hBBBB,1,0,16'h0000));
        vq.push_back(mk(1,0,16'h0000,1,0, 0,8'hFE,0,0,0,16'hBBBB,1,0,16'h0001));
        vq.push_back(mk(1,1,16'h2222,1,0, 0,8'hFE,0,0,0,16'hBBBB,1,0,16'h0001));
        vq.push_back(mk(1,0,16'h0000,1,0, 0,8'hFE,0,0,0,16'hBBBB,1,0,16'h0002));
        vq.push_back(mk(1,1,16'h3333,1,0, 0,8'hFE,0,0,0,16'hBBBB,1,0,16'h0002));
        vq.push_back(mk(1,0,16'h0000,1,0, 0,8'hFE,0,0,0,16'hBBBB,1,0,16'h0003));
        vq.push_back(mk(0,0,16'h0000,1,0, 0,8'hFE,0,0,0,16'hBBBB,1,0,16'h0000));
        // backpressure, overrun set/clear priority
        vq.push_back(mk(1,0,16'h0000,0,0, 0,8'hFE,0,0,0,16'hBBBB,1,0,16'h0000));
        vq.push_back(mk(1,1,16'h0020,0,0, 1,8'h20,1,0,0,16'hBBBB,1,0,16'h0000));
        vq.push_back(mk(1,1,16'h5555,0,0, 0,8'h20,1,0,1,16'h5555,0,0,16'h1200));
        vq.push_back(mk(1,1,16'h6666,0,0, 0,8'h20,1,0,1,16'h5555,0,1,16'h1201));
        vq.push_back(mk(1,0,16'h0000,0,1, 0,8'h20,1,0,1,16'h5555,0,0,16'h1202));
        vq.push_back(mk(1,1,16'h7777,0,1, 0,8'h20,1,0,1,16'h5555,0,1,16'h1202));
        vq.push_back(mk(1,0,16'h0000,1,0, 0,8'h20,1,0,0,16'h5555,0,1,16'h1203));
        vq.push_back(mk(0,0,16'h0000,1,0, 0,8'h20,0,1,0,16'h5555,0,1,16'h0000));
        vq.push_back(mk(0,0,16'h0000,1,1, 0,8'h20,0,0,0,16'h5555,0,0,16'h0000));
        // index saturation at IDX_W=2, back-to-back accept + load
        vq.push_back(mk(1,0,16'h0000,1,0, 0,8'h20,0,0,0,16'h5555,0,0,16'h0000));
        vq.push_back(mk(1,1,16'h0030,1,0, 1,8'h30,1,0,0,16'h5555,0,0,16'h0000));
        vq.push_back(mk(1,1,16'h0A00,1,0, 0,8'h30,1,0,1,16'h0A00,0,0,16'h1200));
        vq.push_back(mk(1,1,16'h0A01,1,0, 0,8'h30,1,0,1,16'h0A01,1,0,16'h1201));
        vq.push_back(mk(1,1,16'h0A02,1,0, 0,8'h30,1,0,1,16'h0A02,2,0,16'h1202));
        vq.push_back(mk(1,1,16'h0A03,1,0, 0,8'h30,1,0,1,16'h0A03,3,0,16'h1203));
        vq.push_back(mk(1,1,16'h0A04,1,0, 0,8'h30,1,0,1,16'h0A04,3,0,16'h1203));
        vq.push_back(mk(1,1,16'h0A05,1,0, 0,8'h30,1,0,1,16'h0A05,3,0,16'h1203));
        vq.push_back(mk(0,0,16'h0000,1,0, 0,8'h30,0,1,0,16'h0A05,3,0,16'h0000));
        // strobe while idle, then empty enable pulse
        vq.push_back(mk(0,1,16'h0040,1,0, 0,8'h30,0,0,0,16'h0A05,3,0,16'h0000));
        vq.push_back(mk(1,0,16'h0000,1,0, 0,8'h30,0,0,0,16'h0A05,3,0,16'h0000));
        vq.push_back(mk(0,0,16'h0000,1,0, 0,8'h30,0,0,0,16'h0A05,3,0,16'h0000));
        vq.push_back(mk(0,0,16'h0000,1,0, 0,8'h30,0,0,0,16'h0A05,3,0,16'h0000));

        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].st, vq[i].din, vq[i].rdy, vq[i].clr);
            tick();
            check_all($sformatf("v%0d", i), vq[i].cv, vq[i].code,
                      vq[i].act, vq[i].ce, vq[i].dv, vq[i].dout,
                      vq[i].didx, vq[i].ov, vq[i].iod);
        end

        // reset asserted mid-FWD with a word pending
        drive(1, 0, 16'h0000, 0, 0);
        tick();
        drive(1, 1, 16'h0050, 0, 0);
        tick();
        chk("mr.cmd_valid", 16'(cl.cmd_valid), 16'h1);
        drive(1, 1, 16'h9999, 0, 0);
        tick();
        chk("mr.data_valid", 16'(cl.data_valid), 16'h1);
        chk("mr.data_out", cl.data_out, 16'h9999);
        drive(1, 0, 16'h0000, 0, 0);
        tick();
        #2;
        reset_n   = 1'b0;
        io_enable = 1'b0;
        #1;
        check_all("mid_rst", 0, 8'h00, 0, 0, 0, 16'h0, 0, 0, 16'h0);
        chk("mid_rst.rsp_idx", 16'(cl.rsp_idx), 16'h0);
        @(negedge sys_clk);
        reset_n = 1'b1;
        tick();

        // fresh frame after reset
        drive(1, 0, 16'h0000, 1, 0);
        tick();
        drive(1, 1, 16'h0060, 1, 0);
        tick();
        check_all("pr1", 1, 8'h60, 1, 0, 0, 16'h0, 0, 0, 16'h0);
        drive(1, 1, 16'hCCCC, 1, 0);
        tick();
        check_all("pr2", 0, 8'h60, 1, 0, 1, 16'hCCCC, 0, 0, 16'h1200);
        drive(1, 0, 16'h0000, 1, 0);
        tick();
        check_all("pr3", 0, 8'h60, 1, 0, 0, 16'hCCCC, 0, 0, 16'h1201);
        drive(0, 0, 16'h0000, 1, 0);
        tick();
        check_all("pr4", 0, 8'h60, 0, 1, 0, 16'hCCCC, 0, 0, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
